// File: rtl/quadrilatero_lsu_multi_issue_controller.sv
// In-order LSU issue queue feeding N_UNITS load/store units with round-robin unit selection.
// Latency: push in cycle t -> earliest start_o in t+2. Backpressure: issue_queue_full_o at usage >= N_SLOTS-FULL_MARGIN; pushes to a full queue without a pop are dropped.
// Optional perf counters via QUADRILATERO_LSU_PERF_CNT_EN.
module quadrilatero_lsu_multi_issue_controller #(
  parameter int unsigned N_SLOTS     = 4,
  parameter int unsigned N_UNITS     = 2,
  parameter int unsigned FULL_MARGIN = 1,
  parameter type         lsu_instr_t = logic [31:0],
  parameter type         lsu_conf_t  = logic [15:0]
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 dispatch_i,
  input  lsu_instr_t           dispatched_instr_i,
  input  lsu_conf_t            csr_config_i,
  output logic                 issue_queue_full_o,
  input  logic [N_UNITS-1:0]   busy_i,
  output logic [N_UNITS-1:0]   start_o,
  output lsu_instr_t           issued_instr_o      [N_UNITS],
  output lsu_conf_t            issued_instr_conf_o [N_UNITS],
`ifdef QUADRILATERO_LSU_PERF_CNT_EN
  output logic [31:0]          issued_cnt_o,
  output logic [31:0]          stall_cnt_o,
  output logic [15:0]          drop_cnt_o,
`endif
  output logic                 idle_o
);

  localparam int unsigned PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CW = $clog2(N_SLOTS + 1);
  localparam int unsigned UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  localparam logic [CW-1:0] SLOTS_C   = CW'(N_SLOTS);
  localparam logic [CW-1:0] FULL_TH   = CW'(N_SLOTS - FULL_MARGIN);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_SLOTS - 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(N_UNITS - 1);

  lsu_instr_t        q_mem [N_SLOTS];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     usage_q;
  logic [UW-1:0]     rr_ptr_q;

  logic [N_UNITS-1:0] unit_free;
  logic               sel_vld;
  logic [UW-1:0]      sel_idx;
  logic [UW-1:0]      cand;
  logic               q_nonempty;
  logic               pop;
  logic               push_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // start_o lockout hides the cycle before a started unit raises busy_i
  assign unit_free  = ~busy_i & ~start_o;
  assign q_nonempty = (usage_q != '0);

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = rr_ptr_q;
    for (int k = 0; k < N_UNITS; k++) begin
      if (!sel_vld && unit_free[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
      cand = (cand == UNIT_LAST) ? '0 : cand + UW'(1);
    end
  end

  assign pop      = q_nonempty && sel_vld && !flush_i;
  assign push_acc = dispatch_i && !flush_i && ((usage_q < SLOTS_C) || pop);

  assign issue_queue_full_o = (usage_q >= FULL_TH);
  assign idle_o             = !q_nonempty && (start_o == '0) && (busy_i == '0);

  always_ff @(posedge clk_i) begin
    if (push_acc) q_mem[wr_ptr_q] <= dispatched_instr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
      rr_ptr_q <= '0;
      start_o  <= '0;
      for (int u = 0; u < N_UNITS; u++) begin
        issued_instr_o[u]      <= '0;
        issued_instr_conf_o[u] <= '0;
      end
    end else begin
      start_o <= '0;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        usage_q  <= '0;
      end else begin
        if (push_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop) begin
          rd_ptr_q                     <= ptr_inc(rd_ptr_q);
          start_o[sel_idx]             <= 1'b1;
          issued_instr_o[sel_idx]      <= q_mem[rd_ptr_q];
          issued_instr_conf_o[sel_idx] <= csr_config_i;
          rr_ptr_q                     <= (sel_idx == UNIT_LAST) ? '0 : sel_idx + UW'(1);
        end
        usage_q <= usage_q + CW'(push_acc) - CW'(pop);
      end
    end
  end

`ifdef QUADRILATERO_LSU_PERF_CNT_EN
  logic stall_evt, drop_evt;
  assign stall_evt = q_nonempty && !sel_vld;
  assign drop_evt  = dispatch_i && !flush_i && !push_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_cnt_o <= '0;
      stall_cnt_o  <= '0;
      drop_cnt_o   <= '0;
    end else if (flush_i) begin
      issued_cnt_o <= '0;
      stall_cnt_o  <= '0;
      drop_cnt_o   <= '0;
    end else begin
      if (pop && (issued_cnt_o != '1))      issued_cnt_o <= issued_cnt_o + 32'd1;
      if (stall_evt && (stall_cnt_o != '1)) stall_cnt_o  <= stall_cnt_o + 32'd1;
      if (drop_evt && (drop_cnt_o != '1))   drop_cnt_o   <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule
